accelerator_vector_exponentiator: RTL
=====================================

Name: accelerator_vector_exponentiator

Overview:
- Vector exponentiator accelerator: the device under test driven by the series stimulus block's VECTOR_EXPONENTIATOR_* port group.
- Takes a stream of signed fixed-point elements and returns exp(x) for each element, in order.
- Each element is computed by an internal scalar Taylor-series engine, one series term per two cycles.

Parameters:
- DATA_SIZE, 64, element width; signed two's complement fixed point.
- FRACTION_SIZE, 32, fractional bits. 1.0 = 2^FRACTION_SIZE.
- TERMS, 16, number of series terms (k = 0..TERMS-1). Range 2..32.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  one-cycle pulse; begins a vector operation.
- READY  out  1  one-cycle pulse; vector operation complete.
- DATA_IN_ENABLE  in  1  DATA_IN holds a valid element.
- DATA_OUT_ENABLE  out  1  one-cycle pulse; DATA_OUT holds a valid result.
- SIZE_IN  in  DATA_SIZE  element count, latched at START.
- DATA_IN  in  DATA_SIZE  input element x.
- DATA_OUT  out  DATA_SIZE  exp(x), registered; holds its value between pulses.

Behaviour:
- Reset: RST=1 forces all of the following asynchronously.
  - READY=0, DATA_OUT_ENABLE=0, DATA_OUT=0.
  - Index=0, FSM=STARTER_STATE, scalar engine idle.
  - Reset mid-operation abandons the operation silently; no READY is issued.
- FSM states: STARTER_STATE, INPUT_STATE, COMPUTE_STATE.
  - STARTER_STATE, START=1: latch SIZE_IN, index=0.
    - If SIZE_IN=0: pulse READY next cycle, stay in STARTER_STATE, no DATA_OUT_ENABLE.
    - Otherwise go to INPUT_STATE.
  - INPUT_STATE, DATA_IN_ENABLE=1: latch DATA_IN, pulse scalar START, go to COMPUTE_STATE.
  - COMPUTE_STATE, scalar READY:
    - Register the result into DATA_OUT and pulse DATA_OUT_ENABLE the next cycle.
    - If index = SIZE-1: pulse READY in the same cycle as DATA_OUT_ENABLE and return to STARTER_STATE.
    - Otherwise: index+1, return to INPUT_STATE.
- Ignored inputs:
  - START outside STARTER_STATE is ignored.
  - DATA_IN_ENABLE outside INPUT_STATE is dropped. The driver must wait for DATA_OUT_ENABLE before presenting the next element.
- Scalar engine algorithm:
  - On START: acc=1.0, term=1.0, k=1.
  - Phase A: term = (term*x) >>> FRACTION_SIZE.
  - Phase B: term = (term*RECIP[k]) >>> FRACTION_SIZE; acc += term; k++.
  - Phases alternate, one per cycle. When k reaches TERMS, pulse READY with DATA_OUT=acc.
- Arithmetic and width rules:
  - Products are signed 2*DATA_SIZE bits; the arithmetic right shift truncates toward -infinity.
  - acc wraps modulo 2^DATA_SIZE on overflow; there is no saturation and no flag.
- Latency, engine: START to engine READY = 2*(TERMS-1)+1 cycles (31 at the default).
- Latency, element: DATA_IN_ENABLE to DATA_OUT_ENABLE = 2*(TERMS-1)+3 cycles (33 at the default).
- Simultaneous events: START and DATA_IN_ENABLE in the same STARTER_STATE cycle accepts only START; the element is dropped.

Decomposition:
- Package accelerator_series_pkg holds:
  - FSM state enum (controller states and scalar-engine phase enum).
  - Reciprocal table RECIP[k] = round(2^FRACTION_SIZE / k) for k=1..32, as a DATA_SIZE-wide constant array.
  - The ONE constant (1 << FRACTION_SIZE).
- Sub-module accelerator_scalar_exponentiator (CLK, RST, START, READY, DATA_IN, DATA_OUT) contains the series engine.
- The top contains only the vector controller.

Test Plan:
- Zero input: SIZE=1, x=0 -> one DATA_OUT_ENABLE, DATA_OUT=0x0000_0001_0000_0000 exactly, READY in the same cycle, 33 cycles after DATA_IN_ENABLE.
- Unit input: SIZE=3, x=1.0, 2.0, -1.0 -> outputs within 2^-20 relative of e, e^2, e^-1 (e = 0x2_B7E1_5162 approx), in order; READY only with the third DATA_OUT_ENABLE.
- Empty vector: START with SIZE=0 -> READY one cycle later; DATA_OUT_ENABLE never asserts; DATA_OUT unchanged.
- Protocol abuse:
  - START pulsed during COMPUTE_STATE -> ignored; the vector completes normally.
  - DATA_IN_ENABLE during COMPUTE_STATE -> dropped; output count still equals SIZE.
- Reset mid-operation: assert RST 10 cycles into element 2 of a SIZE=4 vector.
  - Required: all outputs 0 immediately; no READY.
  - A following START with SIZE=1, x=0 yields 1.0 normally.
- Back-to-back vectors: START asserted the cycle after READY -> accepted; results are correct for both vectors.

Source files
------------

// File: rtl/accelerator_vector_exponentiator_pkg.sv
// Shared types and constants for the vector exponentiator and its scalar series engine.
// Holds the controller/engine state enums, the fixed-point 1.0 constant and the 1/k table.
// Pure declarations; no clocked logic lives here.
package accelerator_series_pkg;

  localparam int DATA_SIZE     = 64;
  localparam int FRACTION_SIZE = 32;
  localparam int RECIP_MAX     = 32;

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1) << FRACTION_SIZE;

  typedef enum logic [1:0] {
    STARTER_STATE,
    INPUT_STATE,
    COMPUTE_STATE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PHASE_IDLE,
    PHASE_MUL_X,
    PHASE_MUL_RECIP
  } phase_t;

  // round(ONE / k), rounding halves upward
  function automatic logic [DATA_SIZE-1:0] recip(input int k);
    return (ONE + DATA_SIZE'(k / 2)) / DATA_SIZE'(k);
  endfunction

  // Entry 0 is never addressed; the series starts at k = 1.
  localparam logic [DATA_SIZE-1:0] RECIP [0:RECIP_MAX] = '{
    '0,
    recip(1),  recip(2),  recip(3),  recip(4),  recip(5),  recip(6),  recip(7),  recip(8),
    recip(9),  recip(10), recip(11), recip(12), recip(13), recip(14), recip(15), recip(16),
    recip(17), recip(18), recip(19), recip(20), recip(21), recip(22), recip(23), recip(24),
    recip(25), recip(26), recip(27), recip(28), recip(29), recip(30), recip(31), recip(32)
  };

endpackage

// File: rtl/accelerator_vector_exponentiator_if.sv
// Element stream bus between a driver and the vector exponentiator.
// Carries the vector start/done pulses, element strobes and data.
// No backpressure: the driver waits for DATA_OUT_ENABLE before the next element.
interface accelerator_vector_exponentiator_if;
  import accelerator_series_pkg::*;

  logic                 START;
  logic                 READY;
  logic                 DATA_IN_ENABLE;
  logic                 DATA_OUT_ENABLE;
  logic [DATA_SIZE-1:0] SIZE_IN;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START, DATA_IN_ENABLE, SIZE_IN, DATA_IN,
    input  READY, DATA_OUT_ENABLE, DATA_OUT
  );

  modport slave (
    input  START, DATA_IN_ENABLE, SIZE_IN, DATA_IN,
    output READY, DATA_OUT_ENABLE, DATA_OUT
  );

endinterface

// File: rtl/accelerator_vector_exponentiator_scalar.sv
// Scalar exp(x) engine: Taylor series, one term per two cycles (multiply by x, then by 1/k).
// Latency START -> READY is 2*(TERMS-1)+1 cycles.
// START while busy is ignored; no backpressure on READY.
module accelerator_scalar_exponentiator
  import accelerator_series_pkg::*;
#(
  parameter int TERMS = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int PROD_SIZE = 2 * DATA_SIZE;
  localparam logic [5:0] K_LAST = 6'(TERMS - 1);

  phase_t               phase, phase_next;
  logic [5:0]           k;
  logic [DATA_SIZE-1:0] x_q, term, acc;
  logic [DATA_SIZE-1:0] mult_operand, term_next;
  logic signed [PROD_SIZE-1:0] op_a, op_b, prod;
  logic                 last_term;

  assign last_term = (k == K_LAST);
  assign DATA_OUT  = acc;

  // Shared multiplier: term*x in phase A, term*(1/k) in phase B; floor shift back to fixed point
  always_comb begin
    mult_operand = (phase == PHASE_MUL_X) ? x_q : RECIP[k];
    op_a         = {{DATA_SIZE{term[DATA_SIZE-1]}}, term};
    op_b         = {{DATA_SIZE{mult_operand[DATA_SIZE-1]}}, mult_operand};
    prod         = op_a * op_b;
    term_next    = DATA_SIZE'(prod >>> FRACTION_SIZE);
  end

  // Phase register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) phase <= PHASE_IDLE;
    else     phase <= phase_next;
  end

  // Phase sequencing: A/B alternate until the last term has been accumulated
  always_comb begin
    phase_next = phase;
    case (phase)
      PHASE_IDLE:      if (START) phase_next = PHASE_MUL_X;
      PHASE_MUL_X:     phase_next = PHASE_MUL_RECIP;
      PHASE_MUL_RECIP: phase_next = last_term ? PHASE_IDLE : PHASE_MUL_X;
      default:         phase_next = PHASE_IDLE;
    endcase
  end

  // Series datapath; acc wraps on overflow by design
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k     <= '0;
      x_q   <= '0;
      term  <= '0;
      acc   <= '0;
      READY <= 1'b0;
    end else begin
      READY <= 1'b0;
      case (phase)
        PHASE_IDLE: begin
          if (START) begin
            x_q  <= DATA_IN;
            term <= ONE;
            acc  <= ONE;
            k    <= 6'd1;
          end
        end
        PHASE_MUL_X: term <= term_next;
        PHASE_MUL_RECIP: begin
          term  <= term_next;
          acc   <= acc + term_next;
          k     <= k + 6'd1;
          READY <= last_term;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/accelerator_vector_exponentiator.sv
// Vector controller: feeds elements one at a time to the scalar exp engine and returns results in order.
// Latency DATA_IN_ENABLE -> DATA_OUT_ENABLE is 2*(TERMS-1)+3 cycles.
// No backpressure; elements arriving outside INPUT_STATE are dropped.
module accelerator_vector_exponentiator
  import accelerator_series_pkg::*;
#(
  parameter int TERMS = 16
) (
  input  logic CLK,
  input  logic RST,
  accelerator_vector_exponentiator_if.slave bus
);

  ctrl_state_t          state, state_next;
  logic [DATA_SIZE-1:0] size_q, index_q, x_q, eng_out;
  logic                 eng_start, eng_ready;
  logic                 accept_start, accept_elem, elem_done, last_elem;

  accelerator_scalar_exponentiator #(.TERMS(TERMS)) u_scalar (
    .CLK      (CLK),
    .RST      (RST),
    .START    (eng_start),
    .READY    (eng_ready),
    .DATA_IN  (x_q),
    .DATA_OUT (eng_out)
  );

  // Controller state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= STARTER_STATE;
    else     state <= state_next;
  end

  // Next state and per-cycle accept/complete strobes
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    accept_elem  = 1'b0;
    elem_done    = 1'b0;
    last_elem    = (index_q + 64'd1 == size_q);
    case (state)
      STARTER_STATE: begin
        if (bus.START) begin
          accept_start = 1'b1;
          if (bus.SIZE_IN != '0) state_next = INPUT_STATE;
        end
      end
      INPUT_STATE: begin
        if (bus.DATA_IN_ENABLE) begin
          accept_elem = 1'b1;
          state_next  = COMPUTE_STATE;
        end
      end
      COMPUTE_STATE: begin
        if (eng_ready) begin
          elem_done  = 1'b1;
          state_next = last_elem ? STARTER_STATE : INPUT_STATE;
        end
      end
      default: state_next = STARTER_STATE;
    endcase
  end

  // Registered outputs, element index and operand capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      size_q              <= '0;
      index_q             <= '0;
      x_q                 <= '0;
      eng_start           <= 1'b0;
      bus.READY           <= 1'b0;
      bus.DATA_OUT_ENABLE <= 1'b0;
      bus.DATA_OUT        <= '0;
    end else begin
      eng_start           <= 1'b0;
      bus.READY           <= 1'b0;
      bus.DATA_OUT_ENABLE <= 1'b0;
      if (accept_start) begin
        size_q  <= bus.SIZE_IN;
        index_q <= '0;
        if (bus.SIZE_IN == '0) bus.READY <= 1'b1;
      end
      if (accept_elem) begin
        x_q       <= bus.DATA_IN;
        eng_start <= 1'b1;
      end
      if (elem_done) begin
        bus.DATA_OUT        <= eng_out;
        bus.DATA_OUT_ENABLE <= 1'b1;
        if (last_elem) bus.READY <= 1'b1;
        else           index_q   <= index_q + 64'd1;
      end
    end
  end

endmodule
